prog_sequencer: RTL and testbench

Top-level run controller for the instruction-fetch unit. On a start request it walks the fetch unit through an enabled subset of up to four resident programs. For each program it drives the fetch unit's program-select and init inputs, waits for the fetch unit's halt pulse, records the run length, then advances to the next program. It sits between the testbench/host start logic and the fetch unit's `Init`/`ProgState`/`Halt` pins.

---
 rtl/prog_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_prog_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller for the instruction-fetch unit.
// Walks the fetch unit through the enabled subset of up to four resident
// programs in ascending index order: load (FetchInit high for INIT_CYCLES),
// run until Halt, record the run length, advance. Synchronous active-high
// reset on Init.
// Optional feature: define PROG_WATCHDOG_EN to abort a program whose run
// reaches WDOG_LIMIT cycles without Halt; Timeout then flags the abort.
module prog_sequencer #(
  parameter int NUM_PROGS   = 3,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16,
  parameter int WDOG_LIMIT  = 1023
) (
  input  logic                 CLK,
  input  logic                 Init,
  input  logic                 Start,
  input  logic [NUM_PROGS-1:0] ProgMask,
  input  logic                 Halt,
  output logic                 FetchInit,
  output logic [1:0]           ProgState,
  output logic                 Busy,
  output logic                 Done,
  output logic                 ProgDone,
  output logic [CNT_W-1:0]     LastCycles,
  output logic                 Timeout
);

  // Reject configurations the controller cannot represent.
  if (NUM_PROGS < 1 || NUM_PROGS > 4 || INIT_CYCLES < 1 || WDOG_LIMIT < 1)
  begin : g_bad_params
    $error("prog_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_e;

  // Load counter only has to count 0..INIT_CYCLES-1.
  localparam int LOAD_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(INIT_CYCLES - 1);

`ifdef PROG_WATCHDOG_EN
  // Counter value seen during the WDOG_LIMIT-th run cycle.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);
`endif

  // Index of the lowest set bit; programs always run in ascending order.
  function automatic logic [1:0] lowest_bit(input logic [NUM_PROGS-1:0] m);
    lowest_bit = 2'd0;
    for (int i = NUM_PROGS - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = 2'(i);
    end
  endfunction

  state_e                 state_q, state_d;
  logic [NUM_PROGS-1:0]   mask_q, mask_d;
  logic [NUM_PROGS-1:0]   mask_rem;
  logic [1:0]             idx_q, idx_d;
  logic [LOAD_W-1:0]      load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]       run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]       run_cnt_inc;
  logic                   fetch_init_q, fetch_init_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   prog_done_q, prog_done_d;
  logic [CNT_W-1:0]       last_cycles_q, last_cycles_d;
`ifdef PROG_WATCHDOG_EN
  logic                   timeout_q, timeout_d;
`endif

  // Next-state, counters and registered-output precomputation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers latches.
    state_d       = state_q;
    mask_d        = mask_q;
    mask_rem      = mask_q & ~(NUM_PROGS'(1) << idx_q);
    idx_d         = idx_q;
    load_cnt_d    = load_cnt_q;
    run_cnt_d     = run_cnt_q;
    run_cnt_inc   = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
    prog_done_d   = 1'b0;
    last_cycles_d = last_cycles_q;
`ifdef PROG_WATCHDOG_EN
    timeout_d     = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mask_d = ProgMask;
`ifdef PROG_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
          if (ProgMask == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d      = lowest_bit(ProgMask);
            load_cnt_d = '0;
            run_cnt_d  = '0;
            state_d    = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d = S_RUN;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        run_cnt_d = run_cnt_inc;
        // A zero counter marks the first RUN cycle, where a stale halt from
        // the previous program may still be asserted.
        if (Halt && run_cnt_q != '0) begin
          last_cycles_d = run_cnt_inc;
          prog_done_d   = 1'b1;
          state_d       = S_NEXT;
        end
`ifdef PROG_WATCHDOG_EN
        else if (run_cnt_q == WDOG_LAST) begin
          last_cycles_d = CNT_W'(WDOG_LIMIT);
          prog_done_d   = 1'b1;
          timeout_d     = 1'b1;
          state_d       = S_NEXT;
        end
`endif
      end

      S_NEXT: begin
        mask_d = mask_rem;
        if (mask_rem != '0) begin
          idx_d      = lowest_bit(mask_rem);
          load_cnt_d = '0;
          run_cnt_d  = '0;
          state_d    = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        idx_d   = 2'd0;
        state_d = S_IDLE;
      end

      default: begin
        idx_d   = 2'd0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    fetch_init_d = (state_d == S_IDLE) || (state_d == S_LOAD) ||
                   (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset on Init.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Init) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      idx_q         <= 2'd0;
      load_cnt_q    <= '0;
      run_cnt_q     <= '0;
      fetch_init_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      prog_done_q   <= 1'b0;
      last_cycles_q <= '0;
`ifdef PROG_WATCHDOG_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      load_cnt_q    <= load_cnt_d;
      run_cnt_q     <= run_cnt_d;
      fetch_init_q  <= fetch_init_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      prog_done_q   <= prog_done_d;
      last_cycles_q <= last_cycles_d;
`ifdef PROG_WATCHDOG_EN
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign FetchInit  = fetch_init_q;
  assign ProgState  = idx_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign ProgDone   = prog_done_q;
  assign LastCycles = last_cycles_q;
`ifdef PROG_WATCHDOG_EN
  assign Timeout    = timeout_q;
`else
  assign Timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer (NUM_PROGS=3, INIT_CYCLES=3,
// WDOG_LIMIT=50). Inputs are driven and outputs sampled 1 ns after each
// rising edge; a negedge monitor counts output pulses.
module tb_prog_sequencer;

  localparam int NP = 3;
  localparam int IC = 3;
  localparam int CW = 16;
  localparam int WL = 50;

  logic          clk = 1'b0;
  logic          init;
  logic          start;
  logic [NP-1:0] mask;
  logic          halt;
  logic          fetch_init;
  logic [1:0]    prog_state;
  logic          busy;
  logic          done;
  logic          prog_done;
  logic [CW-1:0] last_cycles;
  logic          timeout;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int pd_seen = 0;
  int fi_low_seen = 0;
  int p1_load_seen = 0;

  prog_sequencer #(
    .NUM_PROGS(NP), .INIT_CYCLES(IC), .CNT_W(CW), .WDOG_LIMIT(WL)
  ) u_dut (
    .CLK(clk), .Init(init), .Start(start), .ProgMask(mask), .Halt(halt),
    .FetchInit(fetch_init), .ProgState(prog_state), .Busy(busy),
    .Done(done), .ProgDone(prog_done), .LastCycles(last_cycles),
    .Timeout(timeout)
  );

  always #5 clk = ~clk;

  // Pulse and event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen <= done_seen + 1;
    if (prog_done === 1'b1) pd_seen <= pd_seen + 1;
    if (fetch_init === 1'b0) fi_low_seen <= fi_low_seen + 1;
    if (fetch_init === 1'b1 && busy === 1'b1 && done === 1'b0 &&
        prog_state === 2'd1)
      p1_load_seen <= p1_load_seen + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge that entered LOAD; ends in RUN cycle 1.
  task automatic run_load(input logic [1:0] idx);
    for (int k = 0; k < IC; k++) begin
      tests++;
      if (fetch_init !== 1'b1 || prog_state !== idx) begin
        fails++;
        $display("FAIL load_cycle%0d: fetch_init=%b prog_state=%0d, expected fetch_init=1 prog_state=%0d",
                 k, fetch_init, prog_state, idx);
      end
      step();
    end
    tests++;
    if (fetch_init !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL run_entry: fetch_init=%b busy=%b, expected fetch_init=0 busy=1",
               fetch_init, busy);
    end
  endtask

  // Called in RUN cycle 1; halts in RUN cycle n and ends in NEXT.
  task automatic run_halt(input int n, input logic [1:0] idx);
    repeat (n - 1) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    tests++;
    if (prog_done !== 1'b1 || last_cycles !== CW'(n)) begin
      fails++;
      $display("FAIL halt_record: prog_done=%b last_cycles=%0d, expected prog_done=1 last_cycles=%0d",
               prog_done, last_cycles, n);
    end
    tests++;
    if (fetch_init !== 1'b0 || prog_state !== idx) begin
      fails++;
      $display("FAIL next_outputs: fetch_init=%b prog_state=%0d, expected fetch_init=0 prog_state=%0d",
               fetch_init, prog_state, idx);
    end
  endtask

  task automatic test_reset();
    init = 1'b1;
    step();
    step();
    tests++;
    if (fetch_init !== 1'b1 || prog_state !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: fetch_init=%b prog_state=%0d busy=%b, expected 1/0/0",
               fetch_init, prog_state, busy);
    end
    tests++;
    if (done !== 1'b0 || prog_done !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: done=%b prog_done=%b timeout=%b, expected 0/0/0",
               done, prog_done, timeout);
    end
    tests++;
    if (last_cycles !== 16'd0) begin
      fails++;
      $display("FAIL reset_last_cycles: got %0d expected 0", last_cycles);
    end
    init = 1'b0;
    step();
  endtask

  task automatic test_two_programs();
    int d0, p0, l0;
    d0 = done_seen; p0 = pd_seen; l0 = p1_load_seen;
    start = 1'b1; mask = 3'b101;
    step();
    start = 1'b0; mask = 3'b000;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_rise: got %b expected 1", busy);
    end
    run_load(2'd0);
    run_halt(29, 2'd0);
    step();
    run_load(2'd2);
    run_halt(14, 2'd2);
    step();
    tests++;
    if (done !== 1'b1 || fetch_init !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL done_cycle: done=%b fetch_init=%b busy=%b, expected 1/1/1",
               done, fetch_init, busy);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || prog_state !== 2'd0) begin
      fails++;
      $display("FAIL back_to_idle: done=%b busy=%b prog_state=%0d, expected 0/0/0",
               done, busy, prog_state);
    end
    tests++;
    if (pd_seen - p0 !== 2 || done_seen - d0 !== 1) begin
      fails++;
      $display("FAIL pulse_counts: prog_done=%0d done=%0d, expected 2 and 1",
               pd_seen - p0, done_seen - d0);
    end
    tests++;
    if (p1_load_seen !== l0) begin
      fails++;
      $display("FAIL skip_prog1: program 1 loaded for %0d cycles, expected 0",
               p1_load_seen - l0);
    end
  endtask

  task automatic test_empty_mask();
    int d0, f0;
    d0 = done_seen; f0 = fi_low_seen;
    start = 1'b1; mask = 3'b000;
    step();
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || fetch_init !== 1'b1) begin
      fails++;
      $display("FAIL empty_done: done=%b busy=%b fetch_init=%b, expected 1/1/1",
               done, busy, fetch_init);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL empty_idle: done=%b busy=%b, expected 0/0", done, busy);
    end
    tests++;
    if (fi_low_seen !== f0 || done_seen - d0 !== 1) begin
      fails++;
      $display("FAIL empty_counts: fetch_init low %0d cycles, done %0d, expected 0 and 1",
               fi_low_seen - f0, done_seen - d0);
    end
  endtask

  task automatic test_halt_blanking();
    halt = 1'b1;
    start = 1'b1; mask = 3'b010;
    step();
    start = 1'b0;
    run_load(2'd1);
    start = 1'b1;
    step();
    tests++;
    if (prog_done !== 1'b0 || fetch_init !== 1'b0) begin
      fails++;
      $display("FAIL blank_first_run: prog_done=%b fetch_init=%b, expected 0/0",
               prog_done, fetch_init);
    end
    step();
    halt = 1'b0; start = 1'b0;
    tests++;
    if (prog_done !== 1'b1 || last_cycles !== 16'd2) begin
      fails++;
      $display("FAIL blank_second_run: prog_done=%b last_cycles=%0d, expected 1 and 2",
               prog_done, last_cycles);
    end
    step();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL blank_done: got %b expected 1", done);
    end
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL blank_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0, p0;
    d0 = done_seen; p0 = pd_seen;
    start = 1'b1; mask = 3'b011;
    step();
    start = 1'b0;
    run_load(2'd0);
    run_halt(3, 2'd0);
    step();
    run_load(2'd1);
    repeat (7) step();
    init = 1'b1;
    step();
    init = 1'b0;
    tests++;
    if (fetch_init !== 1'b1 || prog_state !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: fetch_init=%b prog_state=%0d busy=%b, expected 1/0/0",
               fetch_init, prog_state, busy);
    end
    tests++;
    if (last_cycles !== 16'd0 || prog_done !== 1'b0) begin
      fails++;
      $display("FAIL midrun_clear: last_cycles=%0d prog_done=%b, expected 0/0",
               last_cycles, prog_done);
    end
    halt = 1'b1;
    step();
    halt = 1'b0;
    repeat (4) step();
    tests++;
    if (done_seen !== d0 || pd_seen - p0 !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrun_abort: done=%0d prog_done=%0d busy=%b, expected 0, 1, 0",
               done_seen - d0, pd_seen - p0, busy);
    end
  endtask

`ifdef PROG_WATCHDOG_EN
  task automatic test_watchdog();
    start = 1'b1; mask = 3'b011;
    step();
    start = 1'b0;
    run_load(2'd0);
    repeat (WL - 1) step();
    tests++;
    if (prog_done !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL wdog_early: prog_done=%b timeout=%b, expected 0/0",
               prog_done, timeout);
    end
    step();
    tests++;
    if (prog_done !== 1'b1 || last_cycles !== 16'd50 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL wdog_fire: prog_done=%b last_cycles=%0d timeout=%b, expected 1, 50, 1",
               prog_done, last_cycles, timeout);
    end
    step();
    run_load(2'd1);
    run_halt(5, 2'd1);
    step();
    step();
    tests++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wdog_sticky: timeout=%b busy=%b, expected 1/0", timeout, busy);
    end
    start = 1'b1; mask = 3'b001;
    step();
    start = 1'b0;
    tests++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL wdog_clear: timeout=%b expected 0", timeout);
    end
    run_load(2'd0);
    run_halt(4, 2'd0);
    step();
    step();
  endtask
`else
  task automatic test_no_watchdog();
    int p0;
    p0 = pd_seen;
    start = 1'b1; mask = 3'b001;
    step();
    start = 1'b0;
    run_load(2'd0);
    repeat (60) step();
    tests++;
    if (fetch_init !== 1'b0 || pd_seen !== p0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL no_wdog_wait: fetch_init=%b prog_done=%0d timeout=%b, expected 0, 0, 0",
               fetch_init, pd_seen - p0, timeout);
    end
    halt = 1'b1;
    step();
    halt = 1'b0;
    tests++;
    if (prog_done !== 1'b1 || last_cycles !== 16'd61) begin
      fails++;
      $display("FAIL no_wdog_long_run: prog_done=%b last_cycles=%0d, expected 1 and 61",
               prog_done, last_cycles);
    end
    step();
    step();
  endtask
`endif

  initial begin
    init = 1'b1; start = 1'b0; mask = 3'b000; halt = 1'b0;
    test_reset();
    test_two_programs();
    test_empty_mask();
    test_halt_blanking();
    test_reset_mid_run();
`ifdef PROG_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
